// File: rtl/relu_arbiter.sv
// Round-robin arbiter over four signed 8-bit activation requesters with per-requester
// optional ReLU, a single-entry output register and a saturating zeroed-value counter.
module relu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_valid,
  output logic [3:0]  req_ready,
  input  logic [3:0]  cfg_relu_en,
  output logic [7:0]  out_data,
  output logic [1:0]  out_id,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        stat_clr,
  output logic [15:0] stat_zero_cnt
);

  logic [1:0]  r_ptr;
  logic        r_outValid;
  logic [7:0]  r_outData;
  logic [1:0]  r_outId;
  logic [15:0] r_zeroCnt;

  logic        w_accept;
  logic        w_anyValid;
  logic        w_transfer;
  logic [1:0]  w_grant;
  logic [7:0]  w_byte;
  logic        w_zeroed;

  // First valid requester at or after the pointer, wrapping modulo four.
  always_comb begin
    logic [1:0] idx;
    w_grant    = r_ptr;
    w_anyValid = 1'b0;
    idx        = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = r_ptr + 2'(k);
      if (!w_anyValid && req_valid[idx]) begin
        w_grant    = idx;
        w_anyValid = 1'b1;
      end
    end
  end

  // Reset gates the handshake so nothing is accepted while rst_n is low.
  always_comb begin
    w_accept   = !r_outValid || out_ready;
    w_transfer = rst_n && w_anyValid && w_accept;
    w_byte     = req_data[{w_grant, 3'b000} +: 8];
    w_zeroed   = cfg_relu_en[w_grant] && w_byte[7];
    req_ready  = w_transfer ? (4'b0001 << w_grant) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outData  <= 8'h00;
      r_outId    <= 2'd0;
      r_ptr      <= 2'd0;
    end else if (w_transfer) begin
      r_outValid <= 1'b1;
      r_outData  <= w_zeroed ? 8'h00 : w_byte;
      r_outId    <= w_grant;
      r_ptr      <= w_grant + 2'd1;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zeroCnt <= 16'h0000;
    end else if (stat_clr) begin
      r_zeroCnt <= 16'h0000;
    end else if (w_transfer && w_zeroed && (r_zeroCnt != 16'hFFFF)) begin
      r_zeroCnt <= r_zeroCnt + 16'h0001;
    end
  end

  assign out_valid     = r_outValid;
  assign out_data      = r_outData;
  assign out_id        = r_outId;
  assign stat_zero_cnt = r_zeroCnt;

endmodule

// File: tb/tb_relu_arbiter.sv
// Directed bench for relu_arbiter: a behavioural model checked every cycle plus
// hand-computed expectations at key points of each scenario.
module tb_relu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  cfg_relu_en;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_valid;
  logic        out_ready;
  logic        stat_clr;
  logic [15:0] stat_zero_cnt;

  int vectors     = 0;
  int miscompares = 0;
  bit cmpEn       = 0;

  bit         mValid;
  logic [7:0] mData;
  logic [1:0] mId;
  int         mPtr;
  int         mCnt;

  relu_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .cfg_relu_en   (cfg_relu_en),
    .out_data      (out_data),
    .out_id        (out_id),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .stat_clr      (stat_clr),
    .stat_zero_cnt (stat_zero_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int modelGrant(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++)
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  // Model: one registered result slot, a round-robin pointer and a saturating count.
  always @(posedge clk) begin : modelUpdate
    int g;
    bit zero;
    logic [7:0] b;
    zero = 0;
    if (!rst_n) begin
      mValid <= 0; mData <= 8'h00; mId <= 2'd0; mPtr <= 0; mCnt <= 0;
    end else begin
      g = modelGrant(req_valid, mPtr);
      if (g >= 0 && (!mValid || out_ready)) begin
        b = req_data[8*g +: 8];
        zero = cfg_relu_en[g] && ($signed(b) < 0);
        mValid <= 1;
        mData  <= zero ? 8'h00 : b;
        mId    <= 2'(g);
        mPtr   <= (g + 1) % 4;
      end else if (out_ready) begin
        mValid <= 0;
      end
      if (stat_clr) mCnt <= 0;
      else if (zero) mCnt <= (mCnt + 1 > 65535) ? 65535 : mCnt + 1;
    end
  end

  always @(negedge clk) begin : compareProc
    int g;
    logic [3:0] expRdy;
    if (cmpEn) begin
      g = modelGrant(req_valid, mPtr);
      expRdy = (rst_n && g >= 0 && (!mValid || out_ready)) ? 4'(1 << g) : 4'b0000;
      checkOutput("model_req_ready", 32'(req_ready), 32'(expRdy));
      checkOutput("model_out_valid", 32'(out_valid), 32'(mValid));
      checkOutput("model_out_data", 32'(out_data), 32'(mData));
      checkOutput("model_out_id", 32'(out_id), 32'(mId));
      checkOutput("model_zero_cnt", 32'(stat_zero_cnt), 32'(mCnt));
    end
  end

  task automatic applyStimulus(input logic rst, input logic [3:0] valid, input logic [3:0] relu,
                               input logic [31:0] data, input logic ordy, input logic clr);
    rst_n = rst; req_valid = valid; cfg_relu_en = relu;
    req_data = data; out_ready = ordy; stat_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResult(input string name, input logic [1:0] id, input logic [7:0] data);
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, "_id"}, 32'(out_id), 32'(id));
    checkOutput({name, "_data"}, 32'(out_data), 32'(data));
  endtask

  logic [7:0] reluTbl [4];
  logic [7:0] passTbl [4];
  localparam logic [31:0] MixData = 32'h7F80F005;

  initial begin
    reluTbl = '{8'h05, 8'h00, 8'h00, 8'h7F};
    passTbl = '{8'h05, 8'hF0, 8'h80, 8'h7F};

    // Reset with all requesters asserting valid.
    applyStimulus(0, 4'b1111, 4'b1111, MixData, 1, 0);
    tick();
    cmpEn = 1;
    tick();
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    checkOutput("rst_zero_cnt", 32'(stat_zero_cnt), 32'h0);

    // Full-throughput round robin with ReLU on every requester.
    applyStimulus(1, 4'b1111, 4'b1111, MixData, 1, 0);
    #1;
    checkOutput("rr_first_ready", 32'(req_ready), 32'h1);
    for (int j = 0; j < 8; j++) begin
      tick();
      checkResult("rr_relu", 2'(j % 4), reluTbl[j % 4]);
    end
    checkOutput("rr_relu_cnt", 32'(stat_zero_cnt), 32'd4);

    // Clear the counter with nothing requesting, then pass-through mode.
    applyStimulus(1, 4'b0000, 4'b0000, MixData, 1, 1);
    tick();
    checkOutput("clr_cnt", 32'(stat_zero_cnt), 32'd0);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1, 4'b1111, 4'b0000, MixData, 1, 0);
    #1;
    checkOutput("pass_first_ready", 32'(req_ready), 32'h1);
    for (int j = 0; j < 4; j++) begin
      tick();
      checkResult("pass", 2'(j), passTbl[j]);
    end
    checkOutput("pass_cnt", 32'(stat_zero_cnt), 32'd0);

    // Backpressure: result held, no grants, pointer frozen.
    applyStimulus(1, 4'b1111, 4'b0000, MixData, 0, 0);
    #1;
    checkOutput("bp_ready", 32'(req_ready), 32'h0);
    for (int j = 0; j < 3; j++) begin
      tick();
      checkResult("bp_hold", 2'd3, 8'h7F);
      checkOutput("bp_hold_ready", 32'(req_ready), 32'h0);
    end
    out_ready = 1;
    #1;
    checkOutput("bp_release_ready", 32'(req_ready), 32'h1);
    tick();
    checkResult("bp_resume", 2'd0, 8'h05);

    // Pointer wrap: only requester 2, then 2 and 3 together with ptr at 3.
    applyStimulus(1, 4'b0100, 4'b1111, MixData, 1, 0);
    #1;
    checkOutput("wrap_ready_a", 32'(req_ready), 32'h4);
    tick();
    checkResult("wrap_a", 2'd2, 8'h00);
    #1;
    checkOutput("wrap_ready_b", 32'(req_ready), 32'h4);
    tick();
    checkResult("wrap_b", 2'd2, 8'h00);
    req_valid = 4'b1100;
    #1;
    checkOutput("wrap_ready_c", 32'(req_ready), 32'h8);
    tick();
    checkResult("wrap_c", 2'd3, 8'h7F);
    #1;
    checkOutput("wrap_ready_d", 32'(req_ready), 32'h4);
    tick();
    checkResult("wrap_d", 2'd2, 8'h00);

    // Mid-stream reset drops the held result and restarts from requester 0.
    applyStimulus(0, 4'b1111, 4'b1111, MixData, 0, 0);
    #1;
    checkOutput("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    checkOutput("mid_rst_valid", 32'(out_valid), 32'h0);
    checkOutput("mid_rst_data", 32'(out_data), 32'h0);
    checkOutput("mid_rst_cnt", 32'(stat_zero_cnt), 32'h0);
    applyStimulus(1, 4'b1110, 4'b1111, MixData, 1, 0);
    #1;
    checkOutput("post_rst_ready", 32'(req_ready), 32'h2);
    tick();
    checkResult("post_rst", 2'd1, 8'h00);
    checkOutput("post_rst_cnt", 32'(stat_zero_cnt), 32'd1);

    // Saturation: 65535 zeroing transfers, one more, then clear against a zeroing transfer.
    applyStimulus(1, 4'b0000, 4'b1111, 32'h80808080, 1, 1);
    tick();
    checkOutput("sat_pre_clr", 32'(stat_zero_cnt), 32'd0);
    applyStimulus(1, 4'b1111, 4'b1111, 32'h80808080, 1, 0);
    repeat (65535) tick();
    checkOutput("sat_full", 32'(stat_zero_cnt), 32'hFFFF);
    tick();
    checkOutput("sat_hold", 32'(stat_zero_cnt), 32'hFFFF);
    stat_clr = 1;
    tick();
    checkOutput("sat_clr_wins", 32'(stat_zero_cnt), 32'd0);
    checkOutput("sat_clr_valid", 32'(out_valid), 32'd1);
    stat_clr = 0;
    tick();
    checkOutput("sat_restart", 32'(stat_zero_cnt), 32'd1);

    applyStimulus(1, 4'b0000, 4'b0000, 32'h0, 1, 0);
    repeat (3) tick();
    cmpEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/relu_arbiter.md
RELU_ARBITER -- requirements
Module: relu_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-003 SHALL have port req_data  input  32  four signed 8-bit activations; requester i at bits [8i+7:8i].
REQ-004 SHALL have port req_valid  input  4  per-requester valid.
REQ-005 SHALL have port req_ready  output  4  per-requester ready; at most one bit high per cycle.
REQ-006 SHALL have port cfg_relu_en  input  4  per-requester mode; 1 = apply ReLU, 0 = pass-through.
REQ-007 SHALL have port out_data  output  8  signed result.
REQ-008 SHALL have port out_id  output  2  index of the requester that produced out_data.
REQ-009 SHALL have port out_valid  output  1  output valid.
REQ-010 SHALL have port out_ready  input  1  downstream ready.
REQ-011 SHALL have port stat_clr  input  1  synchronous clear of zeroed-value counter.
REQ-012 SHALL have port stat_zero_cnt  output  16  count of negative values forced to 0.

Function
REQ-013 SHALL define accept = !out_valid | out_ready (output register empty or draining this cycle).
REQ-014 SHALL select grant as the first requester with req_valid high, searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-015 SHALL drive req_ready[grant] = accept combinationally; all other req_ready bits 0; all bits 0 when no req_valid is high.
REQ-016 SHALL treat a transfer as req_valid[i] & req_ready[i]; exactly one transfer per cycle maximum.
REQ-017 SHALL, on a transfer from requester i, load out_data next cycle with 0 if cfg_relu_en[i]=1 and req_data byte i is negative (bit 7 set), else the byte unchanged; out_id <= i; out_valid <= 1.
REQ-018 SHALL sample cfg_relu_en[i] only in the transfer cycle; later changes do not alter a registered result.
REQ-019 SHALL have a latency of exactly 1 cycle from transfer to out_valid.
REQ-020 SHALL hold out_data and out_id stable while out_valid=1 and out_ready=0.
REQ-021 SHALL clear out_valid on out_valid & out_ready when no transfer occurs in the same cycle; a simultaneous transfer reloads the register (full throughput, 1 result/cycle).
REQ-022 SHALL update ptr <= (grant+1) mod 4 only on a transfer; otherwise ptr holds.
REQ-023 SHALL never deassert no-transfer starvation: every requester holding req_valid is served within 4 transfers.
REQ-024 SHALL increment stat_zero_cnt by 1 on each transfer where a negative value is forced to 0; pass-through negatives and non-negatives do not count.
REQ-025 SHALL saturate stat_zero_cnt at 16'hFFFF.
REQ-026 SHALL give stat_clr priority: counter <= 0 that cycle, any coincident increment discarded.
REQ-027 SHALL treat value -128 (8'h80) as negative and 0 as non-negative.

Reset
REQ-028 SHALL, while rst_n=0 at a clk edge, set out_valid=0, out_data=0, out_id=0, ptr=0, stat_zero_cnt=0.
REQ-029 SHALL drive req_ready=0 during reset cycles and discard any in-flight result when reset asserts mid-stream.
REQ-030 SHALL resume arbitration from requester 0 on the first cycle after rst_n returns high.

Verification
REQ-031 SHALL verify: all 4 valid continuously, out_ready=1, data bytes {0x05,0xF0,0x80,0x7F}, cfg_relu_en=4'b1111 -> out_id sequence 0,1,2,3,0,... with out_data 0x05,0x00,0x00,0x7F, one per cycle, stat_zero_cnt +2 per round.
REQ-032 SHALL verify: cfg_relu_en=4'b0000, same data -> out_data 0x05,0xF0,0x80,0x7F and stat_zero_cnt stays 0.
REQ-033 SHALL verify: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_id unchanged, req_ready=4'b0000, ptr unchanged; first result resumes after out_ready=1.
REQ-034 SHALL verify: only requester 2 valid after ptr=3 -> grant 2, ptr becomes 3; requester 3 then valid with 2 -> 3 granted first.
REQ-035 SHALL verify: stat_zero_cnt preloaded to 0xFFFF via 65535 zeroing transfers, further negative transfer -> stays 0xFFFF; stat_clr coincident with zeroing transfer -> 0.
REQ-036 SHALL verify: rst_n=0 for one cycle while out_valid=1 -> next cycle out_valid=0, out_data=0, stat_zero_cnt=0, first grant after release to lowest-index valid requester from 0.
